// File: rtl/register_cmd_pkg.sv
// register_cmd_pkg: shared types, field positions and status packing for the register command channel
package register_cmd_pkg;
  typedef enum logic [2:0] {
    OP_NOP, OP_WRITE, OP_READ, OP_SET, OP_CLR, OP_CLRALL, OP_RSV6, OP_RSV7
  } opcode_e;
  typedef enum logic [1:0] {RESP_OK, RESP_BAD_OP, RESP_BAD_ADDR, RESP_PARITY} resp_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  localparam int CMD_TGL      = 31;
  localparam int CMD_OP_LSB   = 28;
  localparam int CMD_ADDR_LSB = 16;
  localparam int ST_BUSY      = 31;
  localparam int ST_DONE      = 30;
  localparam int ST_RESP_LSB  = 28;
  localparam int ST_CNT_LSB   = 24;
  function automatic logic [31:0] pack_status(input logic busy, input logic done, input resp_e resp,
                                              input logic [3:0] cnt, input logic [7:0] addr,
                                              input logic [15:0] rdata);
    return {busy, done, resp, cnt, addr, rdata};
  endfunction
endpackage

// File: rtl/register_cmd_if.sv
// register_cmd_if: 32-bit command word in, 32-bit status word out
interface register_cmd_if;
  logic [31:0] register;
  logic [31:0] register_status;
  modport master(output register, input register_status);
  modport slave(input register, output register_status);
endinterface

// File: rtl/register_cmd_regfile.sv
// register_cmd_regfile: DEPTH x 16 config bank with a single commit port and per-register write pulses
module register_cmd_regfile
  import register_cmd_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_commit,
  input  opcode_e               i_op,
  input  logic [7:0]            i_addr,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata,
  output logic [DEPTH*16-1:0]   o_regs,
  output logic [DEPTH-1:0]      o_wr_pulse
);
  logic [15:0] r_regs  [DEPTH];
  logic        r_pulse [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic w_hit;
    assign w_hit = i_commit && i_addr == 8'(i);
    always_ff @(posedge clk) begin
      if (!i_rst_n) begin
        r_regs[i]  <= RST_VAL;
        r_pulse[i] <= 1'b0;
      end else begin
        r_pulse[i] <= w_hit && i_op inside {OP_WRITE, OP_SET, OP_CLR};
        if (i_commit && i_op == OP_CLRALL) r_regs[i] <= RST_VAL;
        else if (w_hit)
          r_regs[i] <= i_op == OP_WRITE ? i_wdata :
                       i_op == OP_SET   ? r_regs[i] | i_wdata :
                       i_op == OP_CLR   ? r_regs[i] & ~i_wdata : r_regs[i];
      end
    end
    assign o_regs[16*i+:16] = r_regs[i];
    assign o_wr_pulse[i]    = r_pulse[i];
  end
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < DEPTH; k++) if (i_addr == 8'(k)) o_rdata = r_regs[k];
  end
endmodule

// File: rtl/register_cmd_responder.sv
// register_cmd_responder: toggle-handshake command endpoint executing ops on a local config bank.
// Optional REGISTER_CMD_PARITY_EN makes bit 27 an even-parity bit over the whole command word.
module register_cmd_responder
  import register_cmd_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter int          EXEC_LAT = 2,
  parameter logic [15:0] RST_VAL  = 16'h0000
) (
  input  logic                register_clk,
  input  logic                register_rst_n,
  register_cmd_if.slave       bus,
  output logic [DEPTH*16-1:0] cfg_regs,
  output logic [DEPTH-1:0]    cfg_wr_pulse
);
`ifdef REGISTER_CMD_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  state_e      r_state, w_next;
  logic [31:0] r_cmd_q, r_lat;
  logic        r_acc_tgl, r_par, r_busy, r_done;
  opcode_e     r_op;
  logic [7:0]  r_addr;
  logic [15:0] r_wdata, r_rdata, w_rf_rdata;
  resp_e       r_resp, w_resp;
  logic [3:0]  r_cnt;
  logic        w_accept, w_last, w_commit, w_bad_addr;
  always_ff @(posedge register_clk) begin
    if (!register_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_accept   = r_state == IDLE && r_cmd_q[CMD_TGL] != r_acc_tgl;
    w_last     = r_state == EXEC && r_lat == 32'(EXEC_LAT - 1);
    w_next     = w_accept ? EXEC : w_last ? RESP : r_state == RESP ? IDLE : r_state;
    w_bad_addr = {24'd0, r_addr} >= 32'(DEPTH);
    w_resp     = PAR_EN && r_par ? RESP_PARITY :
                 r_op inside {OP_RSV6, OP_RSV7} ? RESP_BAD_OP :
                 r_op inside {OP_WRITE, OP_READ, OP_SET, OP_CLR} && w_bad_addr ? RESP_BAD_ADDR : RESP_OK;
    w_commit   = w_last && w_resp == RESP_OK;
  end
  // Parity is reduced at accept so the full word need not be held through EXEC.
  always_ff @(posedge register_clk) begin
    if (!register_rst_n) begin
      r_cmd_q   <= '0;
      r_acc_tgl <= 1'b0;
      r_par     <= 1'b0;
      r_op      <= OP_NOP;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_resp    <= RESP_OK;
      r_cnt     <= '0;
      r_rdata   <= '0;
    end else begin
      r_cmd_q <= bus.register;
      if (w_accept) begin
        r_acc_tgl <= r_cmd_q[CMD_TGL];
        r_par     <= ^r_cmd_q;
        r_op      <= opcode_e'(r_cmd_q[CMD_OP_LSB+:3]);
        r_addr    <= r_cmd_q[CMD_ADDR_LSB+:8];
        r_wdata   <= r_cmd_q[15:0];
        r_lat     <= '0;
        r_busy    <= 1'b1;
      end
      if (r_state == EXEC) r_lat <= r_lat + 32'd1;
      if (r_state == RESP) begin
        r_busy  <= 1'b0;
        r_done  <= r_acc_tgl;
        r_resp  <= w_resp;
        r_cnt   <= r_cnt + 4'd1;
        r_rdata <= w_resp == RESP_OK && r_op == OP_READ ? w_rf_rdata : '0;
      end
    end
  end
  register_cmd_regfile #(.DEPTH(DEPTH), .RST_VAL(RST_VAL)) u_regfile (
    .clk        (register_clk),
    .i_rst_n    (register_rst_n),
    .i_commit   (w_commit),
    .i_op       (r_op),
    .i_addr     (r_addr),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rf_rdata),
    .o_regs     (cfg_regs),
    .o_wr_pulse (cfg_wr_pulse)
  );
  assign bus.register_status = pack_status(r_busy, r_done, r_resp, r_cnt, r_addr, r_rdata);
endmodule

// File: tb/tb_register_cmd_responder.sv
// tb_register_cmd_responder: directed and randomized commands checked against a transaction-level model
module tb_register_cmd_responder;
  import register_cmd_pkg::*;
  localparam int          DEPTH    = 16;
  localparam int          EXEC_LAT = 2;
  localparam logic [15:0] RST_VAL  = 16'h0000;
`ifdef REGISTER_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [15:0] wdata;
    bit          bad;
    logic        tgl;
  } cmd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  register_cmd_if bus();
  logic [DEPTH*16-1:0] cfg_regs;
  logic [DEPTH-1:0]    cfg_wr_pulse;
  register_cmd_responder #(.DEPTH(DEPTH), .EXEC_LAT(EXEC_LAT), .RST_VAL(RST_VAL)) dut (
    .register_clk   (clk),
    .register_rst_n (rst_n),
    .bus            (bus),
    .cfg_regs       (cfg_regs),
    .cfg_wr_pulse   (cfg_wr_pulse)
  );
  logic [15:0] m_regs [DEPTH];
  int          m_cnt;
  logic        m_tgl;
  logic [31:0] m_status;
  cmd_t        pend[$];
  int          passes = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  function automatic logic [DEPTH*16-1:0] flat();
    logic [DEPTH*16-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[16*i+:16] = m_regs[i];
    return f;
  endfunction
  task automatic chk(input string name, input logic [DEPTH*16-1:0] act, input logic [DEPTH*16-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("idle_status", bus.register_status, m_status);
      chk("idle_regs", cfg_regs, flat());
      chk("idle_pulse", cfg_wr_pulse, '0);
    end
  end
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = RST_VAL;
    m_cnt = 0;
    m_tgl = 1'b0;
    m_status = '0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.register = '0;
    pend.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_status", bus.register_status, '0);
    chk("rst_regs", cfg_regs, flat());
    chk("rst_pulse", cfg_wr_pulse, '0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_status", bus.register_status, '0);
    chk_en = 1'b1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] wdata, input bit bad);
    logic [31:0] w;
    @(posedge clk); #1;
    m_tgl = ~m_tgl;
    w = {m_tgl, op, 1'b0, 3'($urandom), addr, wdata};
    w[27] = (^w) ^ bad;
    chk_en = 1'b0;
    bus.register = w;
    pend.push_back('{op, addr, wdata, bad, m_tgl});
  endtask
  task automatic complete(input bit chk_lat);
    cmd_t c;
    int n = 0;
    int pcyc = 0;
    logic [DEPTH-1:0] pseen = '0;
    logic [DEPTH-1:0] pexp = '0;
    logic [1:0] resp;
    logic [15:0] rd;
    c = pend.pop_front();
    do begin
      @(negedge clk);
      n++;
      if (cfg_wr_pulse != '0) begin
        pseen |= cfg_wr_pulse;
        pcyc++;
      end
    end while (!(bus.register_status[ST_DONE] == c.tgl && !bus.register_status[ST_BUSY]) && n < 100);
    chk("done_timeout", 1'(n < 100), 1'b1);
    if (chk_lat) chk("latency", n, EXEC_LAT + 4);
    if (PAR_EN && c.bad) resp = 2'd3;
    else if (c.op >= 3'd6) resp = 2'd1;
    else if (c.op inside {[3'd1:3'd4]} && int'(c.addr) >= DEPTH) resp = 2'd2;
    else resp = 2'd0;
    rd = '0;
    if (resp == 2'd0) begin
      if (c.op == 3'd2) rd = m_regs[c.addr];
      if (c.op == 3'd1) m_regs[c.addr] = c.wdata;
      if (c.op == 3'd3) m_regs[c.addr] |= c.wdata;
      if (c.op == 3'd4) m_regs[c.addr] &= ~c.wdata;
      if (c.op == 3'd5) for (int i = 0; i < DEPTH; i++) m_regs[i] = RST_VAL;
      if (c.op inside {3'd1, 3'd3, 3'd4}) pexp[c.addr] = 1'b1;
    end
    m_cnt = (m_cnt + 1) % 16;
    m_status = {1'b0, c.tgl, resp, 4'(m_cnt), c.addr, rd};
    chk("status", bus.register_status, m_status);
    chk("regs", cfg_regs, flat());
    chk("pulse_mask", pseen, pexp);
    chk("pulse_cycles", pcyc, (pexp != '0) ? 1 : 0);
    if (pend.size() == 0) chk_en = 1'b1;
  endtask
  initial begin
    bus.register = '0;
    model_reset();
    do_reset();
    chk("lit_reset", bus.register_status, 32'h0000_0000);
    issue(3'd1, 8'd3, 16'hBEEF, 1'b0);
    complete(1'b1);
    chk("lit_write", bus.register_status, 32'h4103_0000);
    chk("lit_reg3", cfg_regs[16*3+:16], 16'hBEEF);
    issue(3'd2, 8'd3, 16'h0000, 1'b0);
    complete(1'b1);
    chk("lit_read", bus.register_status, 32'h0203_BEEF);
    issue(3'd3, 8'd0, 16'h00F0, 1'b0);
    complete(1'b1);
    issue(3'd4, 8'd0, 16'h000F, 1'b0);
    complete(1'b1);
    issue(3'd2, 8'd0, 16'h0000, 1'b0);
    complete(1'b1);
    chk("lit_setclr", bus.register_status[15:0], 16'h00F0);
    issue(3'd2, 8'(DEPTH), 16'h1234, 1'b0);
    complete(1'b1);
    chk("lit_bad_addr", bus.register_status[29:16], 14'h2610);
    chk("lit_bad_addr_rd", bus.register_status[15:0], 16'h0000);
    issue(3'd7, 8'd1, 16'hFFFF, 1'b0);
    complete(1'b1);
    chk("lit_bad_op", bus.register_status[29:24], 6'h17);
    issue(3'd1, 8'd7, 16'hAAAA, 1'b0);
    repeat (2) @(posedge clk);
    issue(3'd2, 8'd7, 16'h0000, 1'b0);
    complete(1'b0);
    complete(1'b0);
    chk("lit_busy_read", bus.register_status[15:0], 16'hAAAA);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(3'd0, 8'(i), 16'(i), 1'b0);
      complete(1'b1);
    end
    chk("lit_cnt_wrap", bus.register_status[27:24], 4'd1);
    issue(3'd1, 8'd5, 16'h1234, 1'b0);
    @(posedge clk);
    do_reset();
    chk("lit_abort_reg", cfg_regs[16*5+:16], RST_VAL);
    issue(3'd1, 8'd9, 16'h5A5A, 1'b1);
    complete(1'b1);
    chk("lit_parity_resp", bus.register_status[29:28], PAR_EN ? 2'd3 : 2'd0);
    chk("lit_parity_reg", cfg_regs[16*9+:16], PAR_EN ? RST_VAL : 16'h5A5A);
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [7:0]  addr;
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
      issue(op, addr, 16'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        issue(3'($urandom_range(0, 4)), 8'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b0);
        complete(1'b0);
        complete(1'b0);
      end else complete(1'b1);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
